// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-port SDRAM arbiter: default widths,
// read-return tags and FSM state encoding.
package sdram_arb_pkg;

    localparam int DEF_ADDR_W    = 22;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_RD_DEPTH  = 8;
    localparam int DEF_MAX_A_RUN = 8;

    localparam logic TAG_A = 1'b0;
    localparam logic TAG_B = 1'b1;

    localparam logic [1:0] UNLOCKED = 2'd0;
    localparam logic [1:0] LOCK_A   = 2'd1;
    localparam logic [1:0] LOCK_B   = 2'd2;

endpackage

// File: rtl/arb_tag_fifo.sv
// One-bit tag FIFO recording which requester issued each outstanding read,
// so returning SDRAM data can be steered back in issue order.
module arb_tag_fifo #(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             push_tag,
    input  logic             pop,
    output logic             head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO is only safe when a pop frees a slot the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between a priority requester (A, audio)
// and a secondary requester (B), with in-order read-data return by tag.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RD_DEPTH  = DEF_RD_DEPTH,
    parameter int MAX_A_RUN = DEF_MAX_A_RUN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_read,
    input  logic              a_write,
    output logic              a_waitrq,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              b_read,
    input  logic              b_write,
    output logic              b_waitrq,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_read,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_data_out,
    input  logic              ram_valid,
    input  logic              ram_waitrq,
    output logic              err_orphan
);

    localparam int CNT_W = $clog2(RD_DEPTH) + 1;
    localparam int RUN_W = $clog2(MAX_A_RUN + 1);

    logic [1:0]       state;
    logic [RUN_W-1:0] run;
    logic             a_req, b_req;
    logic             a_rd, b_rd;
    logic             a_elig, b_elig;
    logic             grant_a, grant_b;
    logic             fwd, accept, b_turn;
    logic             tag_head, tag_full, tag_empty;
    logic             tag_pop;
    logic [CNT_W-1:0] tag_count_unused;

    assign a_req = a_read | a_write;
    assign b_req = b_read | b_write;
    // A write wins when both strobes are high.
    assign a_rd  = a_read & ~a_write;
    assign b_rd  = b_read & ~b_write;

    // A read cannot compete for the port while the tag FIFO is full.
    assign a_elig = a_write | (a_rd & ~tag_full);
    assign b_elig = b_write | (b_rd & ~tag_full);
    assign b_turn = (run == RUN_W'(MAX_A_RUN));

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state)
            LOCK_A: grant_a = a_elig;
            LOCK_B: grant_b = b_elig;
            default: begin
                if (a_elig && b_elig) begin
                    if (b_turn) grant_b = 1'b1;
                    else        grant_a = 1'b1;
                end else begin
                    grant_a = a_elig;
                    grant_b = b_elig;
                end
            end
        endcase
    end

    assign fwd    = grant_a | grant_b;
    assign accept = fwd & ~ram_waitrq;

    assign ram_addr    = grant_b ? b_addr  : a_addr;
    assign ram_data_in = grant_b ? b_wdata : a_wdata;
    assign ram_read    = (grant_a & a_rd)    | (grant_b & b_rd);
    assign ram_write   = (grant_a & a_write) | (grant_b & b_write);

    // A requester that is not granted must hold; an idle one sees no stall.
    assign a_waitrq = grant_a ? ram_waitrq : a_req;
    assign b_waitrq = grant_b ? ram_waitrq : b_req;

    assign tag_pop = ram_valid & ~tag_empty;

    arb_tag_fifo #(.DEPTH(RD_DEPTH)) u_tag_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (accept & ram_read),
        .push_tag (grant_b ? TAG_B : TAG_A),
        .pop      (tag_pop),
        .head     (tag_head),
        .count    (tag_count_unused),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    // The lock keeps a stalled command on the bus until the controller takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= UNLOCKED;
        end else begin
            case (state)
                UNLOCKED: if (fwd && ram_waitrq) state <= grant_b ? LOCK_B : LOCK_A;
                LOCK_A:   if (!grant_a || !ram_waitrq) state <= UNLOCKED;
                LOCK_B:   if (!grant_b || !ram_waitrq) state <= UNLOCKED;
                default:  state <= UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run <= '0;
        end else if (!b_req || (accept && grant_b)) begin
            run <= '0;
        end else if (accept && grant_a && !b_turn) begin
            run <= run + RUN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rvalid   <= 1'b0;
            b_rvalid   <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
            err_orphan <= 1'b0;
        end else begin
            a_rvalid <= tag_pop && (tag_head == TAG_A);
            b_rvalid <= tag_pop && (tag_head == TAG_B);
            if (tag_pop && tag_head == TAG_A) a_rdata <= ram_data_out;
            if (tag_pop && tag_head == TAG_B) b_rdata <= ram_data_out;
            if (ram_valid && tag_empty) err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: priority, fairness, stall locking,
// tag-FIFO full handling, in-order return, orphan detection and async reset.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [21:0] a_addr, b_addr, ram_addr;
    logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_data_in, ram_data_out;
    logic        a_read, a_write, a_waitrq, a_rvalid;
    logic        b_read, b_write, b_waitrq, b_rvalid;
    logic        ram_read, ram_write, ram_valid, ram_waitrq, err_orphan;

    int vectors    = 0;
    int miscompares = 0;

    always #10 clk = ~clk;

    sdram_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .a_addr       (a_addr),
        .a_wdata      (a_wdata),
        .a_read       (a_read),
        .a_write      (a_write),
        .a_waitrq     (a_waitrq),
        .a_rdata      (a_rdata),
        .a_rvalid     (a_rvalid),
        .b_addr       (b_addr),
        .b_wdata      (b_wdata),
        .b_read       (b_read),
        .b_write      (b_write),
        .b_waitrq     (b_waitrq),
        .b_rdata      (b_rdata),
        .b_rvalid     (b_rvalid),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_read     (ram_read),
        .ram_write    (ram_write),
        .ram_data_out (ram_data_out),
        .ram_valid    (ram_valid),
        .ram_waitrq   (ram_waitrq),
        .err_orphan   (err_orphan)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        a_addr = '0; a_wdata = '0; a_read = 1'b0; a_write = 1'b0;
        b_addr = '0; b_wdata = '0; b_read = 1'b0; b_write = 1'b0;
        ram_data_out = '0; ram_valid = 1'b0; ram_waitrq = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_idle();
        #35;
        reset_n = 1'b1;
        tick();
        vectors++; if (a_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_a_rvalid: got %0h expected 0", a_rvalid); end
        vectors++; if (b_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_b_rvalid: got %0h expected 0", b_rvalid); end
        vectors++; if (a_rdata !== 16'h0) begin miscompares++; $display("FAIL reset_a_rdata: got %0h expected 0", a_rdata); end
        vectors++; if (b_rdata !== 16'h0) begin miscompares++; $display("FAIL reset_b_rdata: got %0h expected 0", b_rdata); end
        vectors++; if (err_orphan !== 1'b0) begin miscompares++; $display("FAIL reset_err_orphan: got %0h expected 0", err_orphan); end
        vectors++; if ({ram_read, ram_write} !== 2'b00) begin miscompares++; $display("FAIL reset_idle_cmd: got %0h expected 0", {ram_read, ram_write}); end
        vectors++; if ({a_waitrq, b_waitrq} !== 2'b00) begin miscompares++; $display("FAIL reset_idle_waitrq: got %0h expected 0", {a_waitrq, b_waitrq}); end
    endtask

    task automatic test_write_read();
        a_write = 1'b1; a_addr = 22'h00123; a_wdata = 16'hBEEF;
        #1;
        vectors++; if ({ram_write, ram_read} !== 2'b10) begin miscompares++; $display("FAIL wr_cmd: got %0h expected 2", {ram_write, ram_read}); end
        vectors++; if (ram_addr !== 22'h00123) begin miscompares++; $display("FAIL wr_addr: got %0h expected 123", ram_addr); end
        vectors++; if (ram_data_in !== 16'hBEEF) begin miscompares++; $display("FAIL wr_data: got %0h expected beef", ram_data_in); end
        vectors++; if (a_waitrq !== 1'b0) begin miscompares++; $display("FAIL wr_waitrq: got %0h expected 0", a_waitrq); end
        tick();
        a_write = 1'b0; a_read = 1'b1;
        #1;
        vectors++; if ({ram_write, ram_read} !== 2'b01) begin miscompares++; $display("FAIL rd_cmd: got %0h expected 1", {ram_write, ram_read}); end
        vectors++; if (ram_addr !== 22'h00123) begin miscompares++; $display("FAIL rd_addr: got %0h expected 123", ram_addr); end
        tick();
        a_read = 1'b0;
        ram_valid = 1'b1; ram_data_out = 16'hBEEF;
        tick();
        ram_valid = 1'b0; ram_data_out = 16'h0;
        vectors++; if (a_rvalid !== 1'b1) begin miscompares++; $display("FAIL rd_rvalid: got %0h expected 1", a_rvalid); end
        vectors++; if (a_rdata !== 16'hBEEF) begin miscompares++; $display("FAIL rd_rdata: got %0h expected beef", a_rdata); end
        vectors++; if (b_rvalid !== 1'b0) begin miscompares++; $display("FAIL rd_b_rvalid: got %0h expected 0", b_rvalid); end
        tick();
        vectors++; if (a_rvalid !== 1'b0) begin miscompares++; $display("FAIL rd_rvalid_pulse: got %0h expected 0", a_rvalid); end
        vectors++; if (a_rdata !== 16'hBEEF) begin miscompares++; $display("FAIL rd_rdata_hold: got %0h expected beef", a_rdata); end
    endtask

    // Continuous reads from both sides: B gets every ninth slot.
    task automatic test_fairness();
        int  a_cnt = 0;
        int  b_cnt = 0;
        logic exp_b;
        a_read = 1'b1; a_addr = 22'h0A0A0;
        b_read = 1'b1; b_addr = 22'h0B0B0;
        for (int i = 0; i < 18; i++) begin
            ram_valid = (i > 0); ram_data_out = 16'(i);
            #1;
            exp_b = (i % 9 == 8);
            vectors++; if (ram_addr !== (exp_b ? 22'h0B0B0 : 22'h0A0A0)) begin miscompares++; $display("FAIL fair_owner[%0d]: got %0h expected_b %0h", i, ram_addr, exp_b); end
            vectors++; if ({a_waitrq, b_waitrq} !== {exp_b, ~exp_b}) begin miscompares++; $display("FAIL fair_waitrq[%0d]: got %0h expected %0h", i, {a_waitrq, b_waitrq}, {exp_b, ~exp_b}); end
            tick();
            a_cnt += int'(a_rvalid); b_cnt += int'(b_rvalid);
        end
        a_read = 1'b0; b_read = 1'b0;
        ram_valid = 1'b1; ram_data_out = 16'h0;
        tick();
        a_cnt += int'(a_rvalid); b_cnt += int'(b_rvalid);
        ram_valid = 1'b0;
        tick();
        vectors++; if (a_cnt !== 16) begin miscompares++; $display("FAIL fair_a_returns: got %0d expected 16", a_cnt); end
        vectors++; if (b_cnt !== 2) begin miscompares++; $display("FAIL fair_b_returns: got %0d expected 2", b_cnt); end
    endtask

    task automatic test_stall_lock();
        b_read = 1'b1; b_addr = 22'h2AAAA; ram_waitrq = 1'b1;
        #1;
        vectors++; if (ram_addr !== 22'h2AAAA || ram_read !== 1'b1) begin miscompares++; $display("FAIL stall_b_fwd: got %0h expected 2aaaa", ram_addr); end
        tick();
        a_read = 1'b1; a_addr = 22'h11111;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++; if (ram_addr !== 22'h2AAAA) begin miscompares++; $display("FAIL stall_hold[%0d]: got %0h expected 2aaaa", i, ram_addr); end
            vectors++; if ({a_waitrq, b_waitrq} !== 2'b11) begin miscompares++; $display("FAIL stall_waitrq[%0d]: got %0h expected 3", i, {a_waitrq, b_waitrq}); end
            tick();
        end
        ram_waitrq = 1'b0;
        #1;
        vectors++; if (ram_addr !== 22'h2AAAA || {a_waitrq, b_waitrq} !== 2'b10) begin miscompares++; $display("FAIL stall_b_accept: got %0h/%0h expected 2aaaa/2", ram_addr, {a_waitrq, b_waitrq}); end
        tick();
        b_read = 1'b0;
        #1;
        vectors++; if (ram_addr !== 22'h11111 || a_waitrq !== 1'b0) begin miscompares++; $display("FAIL stall_a_next: got %0h/%0h expected 11111/0", ram_addr, a_waitrq); end
        tick();
        a_read = 1'b0;
        ram_valid = 1'b1; ram_data_out = 16'h5555;
        tick();
        vectors++; if ({a_rvalid, b_rvalid} !== 2'b01 || b_rdata !== 16'h5555) begin miscompares++; $display("FAIL stall_ret_b: got %0h/%0h expected 1/5555", {a_rvalid, b_rvalid}, b_rdata); end
        ram_data_out = 16'h6666;
        tick();
        ram_valid = 1'b0;
        vectors++; if ({a_rvalid, b_rvalid} !== 2'b10 || a_rdata !== 16'h6666) begin miscompares++; $display("FAIL stall_ret_a: got %0h/%0h expected 2/6666", {a_rvalid, b_rvalid}, a_rdata); end
        tick();
    endtask

    task automatic test_fifo_full();
        int a_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            a_read = 1'b1; a_addr = 22'(i);
            tick();
        end
        a_addr = 22'h8;
        b_write = 1'b1; b_addr = 22'h300; b_wdata = 16'h1234;
        #1;
        vectors++; if ({ram_read, ram_write} !== 2'b01) begin miscompares++; $display("FAIL full_cmd: got %0h expected 1", {ram_read, ram_write}); end
        vectors++; if (ram_addr !== 22'h300 || ram_data_in !== 16'h1234) begin miscompares++; $display("FAIL full_b_write: got %0h/%0h expected 300/1234", ram_addr, ram_data_in); end
        vectors++; if ({a_waitrq, b_waitrq} !== 2'b10) begin miscompares++; $display("FAIL full_waitrq: got %0h expected 2", {a_waitrq, b_waitrq}); end
        tick();
        b_write = 1'b0;
        ram_valid = 1'b1; ram_data_out = 16'h00A0;
        #1;
        vectors++; if (ram_read !== 1'b0 || a_waitrq !== 1'b1) begin miscompares++; $display("FAIL full_registered: got %0h/%0h expected 0/1", ram_read, a_waitrq); end
        tick();
        ram_valid = 1'b0;
        a_cnt += int'(a_rvalid);
        #1;
        vectors++; if (ram_read !== 1'b1 || a_waitrq !== 1'b0 || ram_addr !== 22'h8) begin miscompares++; $display("FAIL full_release: got %0h/%0h/%0h expected 1/0/8", ram_read, a_waitrq, ram_addr); end
        tick();
        a_read = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ram_valid = 1'b1;
            tick();
            a_cnt += int'(a_rvalid);
            vectors++; if (b_rvalid !== 1'b0) begin miscompares++; $display("FAIL full_drain_b[%0d]: got %0h expected 0", i, b_rvalid); end
        end
        ram_valid = 1'b0;
        tick();
        vectors++; if (a_cnt !== 9) begin miscompares++; $display("FAIL full_a_returns: got %0d expected 9", a_cnt); end
    endtask

    task automatic test_interleave();
        logic [15:0] k16;
        for (int i = 0; i < 4; i++) begin
            a_read = (i % 2 == 0); b_read = (i % 2 == 1);
            a_addr = 22'(i + 1); b_addr = 22'(i + 1);
            tick();
        end
        a_read = 1'b0; b_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            k16 = 16'(k + 1);
            ram_valid = 1'b1; ram_data_out = k16;
            tick();
            if (k % 2 == 1) begin
                vectors++; if ({a_rvalid, b_rvalid} !== 2'b01 || b_rdata !== k16) begin miscompares++; $display("FAIL order[%0d]: got %0h/%0h expected 1/%0h", k, {a_rvalid, b_rvalid}, b_rdata, k16); end
            end else begin
                vectors++; if ({a_rvalid, b_rvalid} !== 2'b10 || a_rdata !== k16) begin miscompares++; $display("FAIL order[%0d]: got %0h/%0h expected 2/%0h", k, {a_rvalid, b_rvalid}, a_rdata, k16); end
            end
        end
        ram_valid = 1'b0;
        tick();
    endtask

    task automatic test_orphan_reset();
        ram_valid = 1'b1; ram_data_out = 16'hDEAD;
        tick();
        ram_valid = 1'b0;
        vectors++; if (err_orphan !== 1'b1) begin miscompares++; $display("FAIL orphan_set: got %0h expected 1", err_orphan); end
        vectors++; if ({a_rvalid, b_rvalid} !== 2'b00) begin miscompares++; $display("FAIL orphan_no_rvalid: got %0h expected 0", {a_rvalid, b_rvalid}); end
        tick();
        vectors++; if (err_orphan !== 1'b1) begin miscompares++; $display("FAIL orphan_sticky: got %0h expected 1", err_orphan); end
        a_read = 1'b1; a_addr = 22'h40;
        tick();
        a_addr = 22'h41; ram_waitrq = 1'b1;
        tick();
        #4 reset_n = 1'b0;
        #1;
        vectors++; if (err_orphan !== 1'b0) begin miscompares++; $display("FAIL async_err_orphan: got %0h expected 0", err_orphan); end
        vectors++; if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin miscompares++; $display("FAIL async_rdata: got %0h/%0h expected 0/0", a_rdata, b_rdata); end
        vectors++; if ({a_rvalid, b_rvalid} !== 2'b00) begin miscompares++; $display("FAIL async_rvalid: got %0h expected 0", {a_rvalid, b_rvalid}); end
        a_read = 1'b0; ram_waitrq = 1'b0;
        b_write = 1'b1; b_addr = 22'h77;
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        vectors++; if (b_waitrq !== 1'b0 || ram_write !== 1'b1 || ram_addr !== 22'h77) begin miscompares++; $display("FAIL reset_unlock: got %0h/%0h/%0h expected 0/1/77", b_waitrq, ram_write, ram_addr); end
        tick();
        b_write = 1'b0;
        ram_valid = 1'b1; ram_data_out = 16'hCAFE;
        tick();
        ram_valid = 1'b0;
        vectors++; if (err_orphan !== 1'b1 || a_rvalid !== 1'b0) begin miscompares++; $display("FAIL inflight_orphan: got %0h/%0h expected 1/0", err_orphan, a_rvalid); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fairness();
        test_stall_lock();
        test_fifo_full();
        test_interleave();
        test_orphan_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
